cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single cacheline adaptor / physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches' line-level miss interfaces and the adaptor's LLC-side port.
- Grants one whole 256-bit line transaction at a time.
- Latches the winner's request, holds it on the adaptor port until the response, then inserts one idle cycle so the adaptor returns to its wait state before the next grant.

Parameters:
- ADDR_WIDTH, 32, address width on all ports
- LINE_WIDTH, 256, cache line width on all ports

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_address_i  input  ADDR_WIDTH  icache miss line address
- i_read_i  input  1  icache line read request
- i_line_o  output  LINE_WIDTH  line returned to icache
- i_resp_o  output  1  icache transaction complete
- d_address_i  input  ADDR_WIDTH  dcache line address
- d_read_i  input  1  dcache line read request
- d_write_i  input  1  dcache line writeback request
- d_line_i  input  LINE_WIDTH  dcache writeback data
- d_line_o  output  LINE_WIDTH  line returned to dcache
- d_resp_o  output  1  dcache transaction complete
- mem_address_o  output  ADDR_WIDTH  to adaptor address_i
- mem_read_o  output  1  to adaptor read_i
- mem_write_o  output  1  to adaptor write_i
- mem_line_o  output  LINE_WIDTH  to adaptor line_i
- mem_line_i  input  LINE_WIDTH  from adaptor line_o
- mem_resp_i  input  1  from adaptor resp_o

Behaviour:
- Reset: one clock clk; reset_n is asynchronous, active-low.
  - State goes to IDLE. Latched address, op and line clear to 0. rr_last clears to 0 (meaning icache).
  - All outputs are 0 during and after reset until the first grant.
- States:
  - IDLE: request inputs are sampled every cycle. If any request is present, latch the winner's address, op and (for writes) d_line_i on the clock edge, then go to I_BUSY or D_BUSY. mem_read_o and mem_write_o are 0.
  - I_BUSY / D_BUSY: mem_address_o, mem_read_o, mem_write_o and mem_line_o come from the latches and are held constant. Requester inputs are ignored. Stay until mem_resp_i=1.
    - On mem_resp_i=1, assert the granted requester's resp combinationally in that same cycle. i_resp_o and d_resp_o are never both 1.
    - Then go to RECOVER.
  - RECOVER: exactly 1 cycle. mem_read_o, mem_write_o and both resps are 0. Then go to IDLE.
- Latency:
  - A request first seen in IDLE at edge N gives mem_read_o or mem_write_o = 1 in cycle N+1.
  - Requester resp is 0 cycles after mem_resp_i.
  - Minimum spacing between two back-to-back grants is mem transaction + 2 cycles (RECOVER + IDLE).
- Data return: i_line_o and d_line_o are both wired directly to mem_line_i. Only the resp strobe qualifies the data.
- dcache op select: d_write_i=1 selects write, regardless of d_read_i.
- Requester protocol: a requester holds its request until its resp, then drops it the following cycle. That cycle is RECOVER, so no duplicate grant is issued.
- Boundary cases:
  - Request dropped while BUSY: transaction still completes and resp still pulses.
  - Request rising during RECOVER: ignored until IDLE.
  - Simultaneous icache and dcache requests in IDLE: winner per Optional Feature; loser stays pending and wins next IDLE.
  - reset_n low mid-transaction: immediately go to IDLE and drive all outputs to 0. The in-flight transaction is abandoned and no resp is issued.
- Assertion: mem_resp_i in IDLE or RECOVER is a protocol error. It is ignored and produces no resp.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request the grant goes to the requester that did not win last (per rr_last). rr_last updates on every grant.
- Undefined: fixed priority, dcache always wins ties. rr_last logic is not built.
- Single-requester behaviour is identical either way.

Test Plan:
- Icache read alone, i_address_i=0x0000_1000: mem_read_o=1 and mem_address_o=0x1000 at cycle N+1. Adaptor model returns line 0xA5..A5 with mem_resp_i after 6 cycles → i_resp_o=1 that same cycle, i_line_o=0xA5..A5, d_resp_o=0, then one RECOVER cycle with mem_read_o=0.
- Dcache writeback, d_write_i=1, d_read_i=1, d_address_i=0x2000, d_line_i=0x1234...: mem_write_o=1, mem_read_o=0, mem_line_o equals the latched line. d_line_i changed mid-transaction → mem_line_o unchanged. d_resp_o pulses once.
- Simultaneous icache read 0x100 and dcache read 0x200, macro undefined → 0x200 served first, then 0x100. Repeat three times → dcache wins all three.
- Same as above with ARB_ROUND_ROBIN_EN, both held continuously → grants alternate D, I, D, I (rr_last starts at icache). Exactly 2 idle cycles between transactions.
- reset_n pulled low during D_BUSY → all outputs 0 asynchronously. After release with no requests, stays in IDLE; no d_resp_o is ever issued for the aborted request.
- mem_resp_i forced high in IDLE → no resp output and no state change. Requester dropping its request in BUSY → transaction still completes with resp.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache line-miss ports onto the single cacheline adaptor port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default build gives dcache fixed priority.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] i_address_i,
  input  logic                  i_read_i,
  output logic [LINE_WIDTH-1:0] i_line_o,
  output logic                  i_resp_o,
  input  logic [ADDR_WIDTH-1:0] d_address_i,
  input  logic                  d_read_i,
  input  logic                  d_write_i,
  input  logic [LINE_WIDTH-1:0] d_line_i,
  output logic [LINE_WIDTH-1:0] d_line_o,
  output logic                  d_resp_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [LINE_WIDTH-1:0] mem_line_o,
  input  logic [LINE_WIDTH-1:0] mem_line_i,
  input  logic                  mem_resp_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  iReq, dReq, grantD, busy;

  assign iReq = i_read_i;
  assign dReq = d_read_i | d_write_i;

`ifdef ARB_ROUND_ROBIN_EN
  // rrLast_q = 1 means the dcache won the most recent grant.
  logic rrLast_q, rrLast_d;

  assign grantD = dReq && (!iReq || !rrLast_q);

  always_comb begin
    rrLast_d = rrLast_q;
    if ((state_q == IDLE) && (iReq || dReq)) begin
      rrLast_d = grantD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rrLast_q <= 1'b0;
    end else begin
      rrLast_q <= rrLast_d;
    end
  end
`else
  assign grantD = dReq;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      line_q  <= line_d;
    end
  end

  // Requests are only looked at in IDLE; the latches freeze the winner until RECOVER.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (grantD) begin
          state_d = D_BUSY;
          addr_d  = d_address_i;
          write_d = d_write_i;
          if (d_write_i) begin
            line_d = d_line_i;
          end
        end else if (iReq) begin
          state_d = I_BUSY;
          addr_d  = i_address_i;
          write_d = 1'b0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp_i) begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A stray mem_resp_i outside a busy state is deliberately dropped here.
  always_comb begin
    busy          = (state_q == I_BUSY) || (state_q == D_BUSY);
    mem_address_o = addr_q;
    mem_line_o    = line_q;
    mem_read_o    = busy && !write_q;
    mem_write_o   = busy && write_q;
    i_resp_o      = (state_q == I_BUSY) && mem_resp_i;
    d_resp_o      = (state_q == D_BUSY) && mem_resp_i;
  end

  assign i_line_o = mem_line_i;
  assign d_line_o = mem_line_i;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected grants are queued as requests are driven.
// Honours ARB_ROUND_ROBIN_EN the same way as the design build.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  typedef struct packed {
    logic          isD;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } txn_t;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] i_address_i;
  logic          i_read_i;
  logic [LW-1:0] i_line_o;
  logic          i_resp_o;
  logic [AW-1:0] d_address_i;
  logic          d_read_i;
  logic          d_write_i;
  logic [LW-1:0] d_line_i;
  logic [LW-1:0] d_line_o;
  logic          d_resp_o;
  logic [AW-1:0] mem_address_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [LW-1:0] mem_line_o;
  logic [LW-1:0] mem_line_i;
  logic          mem_resp_i;

  int   checks;
  int   failures;
  bit   modelLastD;
  txn_t sb[$];

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_address_i(i_address_i),
    .i_read_i(i_read_i),
    .i_line_o(i_line_o),
    .i_resp_o(i_resp_o),
    .d_address_i(d_address_i),
    .d_read_i(d_read_i),
    .d_write_i(d_write_i),
    .d_line_i(d_line_i),
    .d_line_o(d_line_o),
    .d_resp_o(d_resp_o),
    .mem_address_o(mem_address_o),
    .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o),
    .mem_line_o(mem_line_o),
    .mem_line_i(mem_line_i),
    .mem_resp_i(mem_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pushTx(input bit isD, input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] line);
    txn_t t;
    t.isD = isD;
    t.wr = wr;
    t.addr = addr;
    t.line = line;
    sb.push_back(t);
    modelLastD = isD;
  endtask

  // Queues both contenders of a tie in the order the arbitration policy serves them.
  task automatic pushTie();
    bit dFirst;
`ifdef ARB_ROUND_ROBIN_EN
    dFirst = !modelLastD;
`else
    dFirst = 1'b1;
`endif
    if (dFirst) begin
      pushTx(1'b1, d_write_i, d_address_i, d_line_i);
      pushTx(1'b0, 1'b0, i_address_i, '0);
    end else begin
      pushTx(1'b0, 1'b0, i_address_i, '0);
      pushTx(1'b1, d_write_i, d_address_i, d_line_i);
    end
  endtask

  task automatic applyStimulus(input bit iRd, input logic [AW-1:0] iAddr, input bit dRd, input bit dWr,
                               input logic [AW-1:0] dAddr, input logic [LW-1:0] dLine);
    i_read_i    = iRd;
    i_address_i = iAddr;
    d_read_i    = dRd;
    d_write_i   = dWr;
    d_address_i = dAddr;
    d_line_i    = dLine;
    if (iRd && (dRd || dWr)) begin
      pushTie();
    end else if (dRd || dWr) begin
      pushTx(1'b1, dWr, dAddr, dLine);
    end else if (iRd) begin
      pushTx(1'b0, 1'b0, iAddr, '0);
    end
  endtask

  task automatic waitGrant(output int idle, output txn_t exp, output bit ok);
    int c;
    idle = 0;
    ok = 1'b0;
    exp = '0;
    c = 0;
    while (!ok && c < 30) begin
      @(negedge clk);
      if (mem_read_o || mem_write_o) begin
        ok = 1'b1;
      end else begin
        idle++;
        c++;
      end
    end
    if (!ok) begin
      checkOutput("grantTimeout", 256'(0), 256'(1));
    end else if (sb.size() == 0) begin
      checkOutput("unexpectedGrant", 256'(1), 256'(0));
      ok = 1'b0;
    end else begin
      exp = sb.pop_front();
      checkOutput("grantAddr", 256'(mem_address_o), 256'(exp.addr));
      checkOutput("grantRead", 256'(mem_read_o), 256'(!exp.wr));
      checkOutput("grantWrite", 256'(mem_write_o), 256'(exp.wr));
      if (exp.wr) begin
        checkOutput("grantLine", mem_line_o, exp.line);
      end
    end
  endtask

  task automatic finishTx(input txn_t exp, input int latency, input logic [LW-1:0] respLine,
                          input bit releaseReq, input bit changeLine);
    for (int k = 2; k <= latency; k++) begin
      @(negedge clk);
      if (changeLine && k == 2) begin
        d_line_i = ~d_line_i;
      end
      checkOutput("heldAddr", 256'(mem_address_o), 256'(exp.addr));
      checkOutput("heldRead", 256'(mem_read_o), 256'(!exp.wr));
      checkOutput("heldWrite", 256'(mem_write_o), 256'(exp.wr));
      if (exp.wr) begin
        checkOutput("heldLine", mem_line_o, exp.line);
      end
      checkOutput("earlyResp", 256'({i_resp_o, d_resp_o}), 256'(0));
    end
    mem_resp_i = 1'b1;
    mem_line_i = respLine;
    #1;
    checkOutput("iResp", 256'(i_resp_o), 256'(!exp.isD));
    checkOutput("dResp", 256'(d_resp_o), 256'(exp.isD));
    checkOutput(exp.isD ? "dLineOut" : "iLineOut", exp.isD ? d_line_o : i_line_o, respLine);
    checkOutput("respExclusive", 256'(i_resp_o & d_resp_o), 256'(0));
    @(negedge clk);
    mem_resp_i = 1'b0;
    checkOutput("recoverRead", 256'(mem_read_o), 256'(0));
    checkOutput("recoverWrite", 256'(mem_write_o), 256'(0));
    checkOutput("recoverResp", 256'({i_resp_o, d_resp_o}), 256'(0));
    if (releaseReq) begin
      if (exp.isD) begin
        d_read_i  = 1'b0;
        d_write_i = 1'b0;
      end else begin
        i_read_i = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   idle;
    txn_t exp;
    bit   ok;
    checks = 0;
    failures = 0;
    modelLastD = 1'b0;
    reset_n = 1'b0;
    i_address_i = '0;
    i_read_i = 1'b0;
    d_address_i = '0;
    d_read_i = 1'b0;
    d_write_i = 1'b0;
    d_line_i = '0;
    mem_line_i = '0;
    mem_resp_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstRead", 256'(mem_read_o), 256'(0));
    checkOutput("rstWrite", 256'(mem_write_o), 256'(0));
    checkOutput("rstAddr", 256'(mem_address_o), 256'(0));
    checkOutput("rstLine", mem_line_o, 256'(0));
    checkOutput("rstResp", 256'({i_resp_o, d_resp_o}), 256'(0));
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstRead", 256'({mem_read_o, mem_write_o}), 256'(0));

    // Lone icache read
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0, '0);
    waitGrant(idle, exp, ok);
    checkOutput("firstLatency", 256'(idle), 256'(0));
    if (ok) finishTx(exp, 6, {32{8'hA5}}, 1'b1, 1'b0);

    // Dcache writeback with read also high; line changes after grant
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_2000, {8{32'h1234_5678}});
    waitGrant(idle, exp, ok);
    checkOutput("recoverGap", 256'(idle), 256'(1));
    if (ok) finishTx(exp, 5, {8{32'h0BAD_F00D}}, 1'b1, 1'b1);

    // Stray mem_resp_i while idle
    @(negedge clk);
    mem_resp_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("strayResp", 256'({i_resp_o, d_resp_o}), 256'(0));
      checkOutput("strayGrant", 256'({mem_read_o, mem_write_o}), 256'(0));
      @(negedge clk);
    end
    mem_resp_i = 1'b0;

    // Icache drops its request while busy
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b0, '0, '0);
    waitGrant(idle, exp, ok);
    checkOutput("idleLatency", 256'(idle), 256'(0));
    i_read_i = 1'b0;
    if (ok) finishTx(exp, 3, {8{32'hCAFE_F00D}}, 1'b0, 1'b0);

    // Simultaneous requests, each requester releasing after its own response
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, '0);
      for (int t = 0; t < 2; t++) begin
        waitGrant(idle, exp, ok);
        if (t == 1) checkOutput("tieGap", 256'(idle), 256'(1));
        if (ok) finishTx(exp, 4, {8{32'h1111_0000 + 32'(r * 2 + t)}}, 1'b1, 1'b0);
      end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Both requests held continuously alternate between the caches
    applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, '0);
    pushTie();
    for (int t = 0; t < 4; t++) begin
      waitGrant(idle, exp, ok);
      if (t > 0) checkOutput("rrGap", 256'(idle), 256'(1));
      if (ok) finishTx(exp, 3, {8{32'h2222_0000 + 32'(t)}}, 1'b0, 1'b0);
    end
    i_read_i = 1'b0;
    d_read_i = 1'b0;
`endif

    // Reset asserted mid dcache transaction
    @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_4000, '0);
    waitGrant(idle, exp, ok);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    mem_line_i = '0;
    #1;
    checkOutput("abortRead", 256'(mem_read_o), 256'(0));
    checkOutput("abortWrite", 256'(mem_write_o), 256'(0));
    checkOutput("abortAddr", 256'(mem_address_o), 256'(0));
    checkOutput("abortLine", mem_line_o, 256'(0));
    checkOutput("abortResp", 256'({i_resp_o, d_resp_o}), 256'(0));
    d_read_i = 1'b0;
    modelLastD = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("postAbortIdle", 256'({mem_read_o, mem_write_o}), 256'(0));
      checkOutput("postAbortResp", 256'(d_resp_o), 256'(0));
    end

    // Normal service resumes after the abort
    applyStimulus(1'b1, 32'h0000_5000, 1'b0, 1'b0, '0, '0);
    waitGrant(idle, exp, ok);
    checkOutput("resumeLatency", 256'(idle), 256'(0));
    if (ok) finishTx(exp, 2, {8{32'h5A5A_5A5A}}, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("sbEmpty", 256'(sb.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
